// File: rtl/multi_cycle_sequencer_if.sv
// Bundle between the control sequencer and the datapath/main control unit.
// Handshakes are level-based: imem_ready and dmem_ready complete the access in the cycle they are sampled high.
interface multi_cycle_sequencer_if;
  logic [3:0]  opcode;
  logic        reg_wr;
  logic        mem_rd;
  logic        mem_wr;
  logic        zf;
  logic        nf;
  logic        imem_ready;
  logic        dmem_ready;
  logic [2:0]  state;
  logic        inst_rd;
  logic        ir_wr;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic        reg_wr_en;
  logic        dmem_rd_en;
  logic        dmem_wr_en;
  logic [15:0] retired;

  modport slave (
    input  opcode, reg_wr, mem_rd, mem_wr, zf, nf, imem_ready, dmem_ready,
    output state, inst_rd, ir_wr, pc_wr, pc_src, reg_wr_en, dmem_rd_en, dmem_wr_en, retired
  );

  modport master (
    output opcode, reg_wr, mem_rd, mem_wr, zf, nf, imem_ready, dmem_ready,
    input  state, inst_rd, ir_wr, pc_wr, pc_src, reg_wr_en, dmem_rd_en, dmem_wr_en, retired
  );
endinterface

// File: rtl/multi_cycle_sequencer.sv
// Fetch/Decode/Execute/Memory/Write-back sequencer for the 16-bit RISC core.
// Gates the main control levels into per-cycle strobes and counts retired instructions.
module multi_cycle_sequencer (
  input  logic                    clk,
  input  logic                    rst,
  multi_cycle_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] retired_q, retired_d;

  logic        inst_rd;
  logic        ir_wr;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic        reg_wr_en;
  logic        dmem_rd_en;
  logic        dmem_wr_en;
  logic        retire;
  logic        taken;

  function automatic logic is_alu(input logic [3:0] op);
    return op <= 4'd4;
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == 4'd5) || (op == 4'd6);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // Branch condition decoded from the latched opcode; flags only matter in EXEC.
  always_comb begin
    taken = 1'b0;
    case (opcode_q[1:0])
      2'b00:   taken = !bus.zf && !bus.nf;
      2'b01:   taken = bus.nf;
      2'b10:   taken = bus.zf;
      default: taken = !bus.zf;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    inst_rd    = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'd0;
    reg_wr_en  = 1'b0;
    dmem_rd_en = 1'b0;
    dmem_wr_en = 1'b0;

    case (state_q)
      S_FETCH: begin
        inst_rd = 1'b1;
        if (bus.imem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Jumps resolve here from the live opcode, in the same cycle it is latched.
        opcode_d = bus.opcode;
        state_d  = S_EXEC;
        if (bus.opcode == 4'd12) begin
          pc_wr   = 1'b1;
          pc_src  = 2'd1;
          state_d = S_FETCH;
        end else if (bus.opcode == 4'd13) begin
          pc_wr     = 1'b1;
          pc_src    = 2'd1;
          reg_wr_en = bus.reg_wr;
          state_d   = S_FETCH;
        end else if (bus.opcode == 4'd14) begin
          pc_wr   = 1'b1;
          pc_src  = 2'd3;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_branch(opcode_q)) begin
          state_d = S_FETCH;
          if (taken) begin
            pc_wr  = 1'b1;
            pc_src = 2'd2;
          end
        end else if (is_alu(opcode_q)) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        dmem_rd_en = bus.mem_rd;
        dmem_wr_en = bus.mem_wr;
        if (bus.dmem_ready) begin
          state_d = is_load(opcode_q) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_wr_en = bus.reg_wr;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A FETCH stall also has next state FETCH but is not an instruction's last cycle.
    retire    = (state_q != S_FETCH) && (state_d == S_FETCH);
    retired_d = retire ? retired_q + 16'd1 : retired_q;

    if (rst) begin
      inst_rd    = 1'b0;
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      pc_src     = 2'd0;
      reg_wr_en  = 1'b0;
      dmem_rd_en = 1'b0;
      dmem_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opcode_q  <= 4'd0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.inst_rd    = inst_rd;
  assign bus.ir_wr      = ir_wr;
  assign bus.pc_wr      = pc_wr;
  assign bus.pc_src     = pc_src;
  assign bus.reg_wr_en  = reg_wr_en;
  assign bus.dmem_rd_en = dmem_rd_en;
  assign bus.dmem_wr_en = dmem_wr_en;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed bench for multi_cycle_sequencer: per-cycle state/strobe vectors and retired counts.
module tb_multi_cycle_sequencer;

  logic clk;
  logic rst;

  multi_cycle_sequencer_if bus();

  multi_cycle_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Strobe vector: {inst_rd, ir_wr, pc_wr, pc_src[1:0], reg_wr_en, dmem_rd_en, dmem_wr_en}
  localparam logic [7:0] NONE       = 8'b0000_0000;
  localparam logic [7:0] FETCH_GO   = 8'b1110_0000;
  localparam logic [7:0] FETCH_WAIT = 8'b1000_0000;
  localparam logic [7:0] JMP_DEC    = 8'b0010_1000;
  localparam logic [7:0] CALL_DEC   = 8'b0010_1100;
  localparam logic [7:0] RET_DEC    = 8'b0011_1000;
  localparam logic [7:0] BR_TAKEN   = 8'b0011_0000;
  localparam logic [7:0] WB_WR      = 8'b0000_0100;
  localparam logic [7:0] MEM_RD     = 8'b0000_0010;
  localparam logic [7:0] MEM_WR     = 8'b0000_0001;

  int unsigned checks;
  int unsigned errors;
  logic [15:0] exp_ret;

  // Branch vectors: opcode, zf, nf, expected taken
  logic [3:0] br_op    [9] = '{4'd10, 4'd11, 4'd8, 4'd8, 4'd8, 4'd9, 4'd9, 4'd10, 4'd11};
  logic       br_zf    [9] = '{1'b1,  1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0};
  logic       br_nf    [9] = '{1'b0,  1'b0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0};
  logic       br_taken [9] = '{1'b1,  1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1'b1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [7:0] strb);
    @(negedge clk);
    check_eq(tag,
             32'({bus.state, bus.inst_rd, bus.ir_wr, bus.pc_wr, bus.pc_src,
                  bus.reg_wr_en, bus.dmem_rd_en, bus.dmem_wr_en}),
             32'({st, strb}));
    @(posedge clk);
    #1;
  endtask

  task automatic check_retired(input string tag);
    check_eq(tag, 32'(bus.retired), 32'(exp_ret));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    exp_ret        = 16'd0;
    rst            = 1'b1;
    bus.opcode     = 4'd0;
    bus.reg_wr     = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.zf         = 1'b0;
    bus.nf         = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;

    @(posedge clk);
    #1;
    expect_cycle("rst_hold", 3'd0, NONE);
    rst = 1'b0;
    check_retired("rst_retired");

    // SW abandoned by reset while the memory access is still pending
    bus.opcode     = 4'd7;
    bus.mem_wr     = 1'b1;
    bus.dmem_ready = 1'b0;
    expect_cycle("sw_fetch", 3'd0, FETCH_GO);
    expect_cycle("sw_dec",   3'd1, NONE);
    expect_cycle("sw_exec",  3'd2, NONE);
    expect_cycle("sw_mem",   3'd3, MEM_WR);
    rst = 1'b1;
    expect_cycle("sw_rst",   3'd3, NONE);
    rst            = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.dmem_ready = 1'b1;
    check_retired("sw_rst_retired");

    // ADD, zero wait states
    bus.opcode = 4'd0;
    bus.reg_wr = 1'b1;
    expect_cycle("add_fetch", 3'd0, FETCH_GO);
    expect_cycle("add_dec",   3'd1, NONE);
    expect_cycle("add_exec",  3'd2, NONE);
    expect_cycle("add_wb",    3'd4, WB_WR);
    exp_ret++;
    check_retired("add_retired");

    // LW with two MEM wait cycles; opcode bus changes after DECODE
    bus.opcode = 4'd5;
    bus.mem_rd = 1'b1;
    expect_cycle("lw_fetch", 3'd0, FETCH_GO);
    expect_cycle("lw_dec",   3'd1, NONE);
    bus.opcode = 4'd0;
    expect_cycle("lw_exec",  3'd2, NONE);
    bus.dmem_ready = 1'b0;
    expect_cycle("lw_mem0",  3'd3, MEM_RD);
    expect_cycle("lw_mem1",  3'd3, MEM_RD);
    bus.dmem_ready = 1'b1;
    expect_cycle("lw_mem2",  3'd3, MEM_RD);
    expect_cycle("lw_wb",    3'd4, WB_WR);
    exp_ret++;
    check_retired("lw_retired");
    bus.mem_rd = 1'b0;

    // Store opcode 1111 completing at once
    bus.opcode = 4'd15;
    bus.reg_wr = 1'b0;
    bus.mem_wr = 1'b1;
    expect_cycle("sw15_fetch", 3'd0, FETCH_GO);
    expect_cycle("sw15_dec",   3'd1, NONE);
    expect_cycle("sw15_exec",  3'd2, NONE);
    expect_cycle("sw15_mem",   3'd3, MEM_WR);
    exp_ret++;
    check_retired("sw15_retired");
    bus.mem_wr = 1'b0;

    // Instruction memory stall
    bus.imem_ready = 1'b0;
    expect_cycle("fetch_wait", 3'd0, FETCH_WAIT);
    bus.imem_ready = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus.opcode = br_op[i];
      bus.zf     = br_zf[i];
      bus.nf     = br_nf[i];
      expect_cycle($sformatf("br%0d_fetch", i), 3'd0, FETCH_GO);
      expect_cycle($sformatf("br%0d_dec", i),   3'd1, NONE);
      expect_cycle($sformatf("br%0d_exec", i),  3'd2, br_taken[i] ? BR_TAKEN : NONE);
      exp_ret++;
      check_retired($sformatf("br%0d_retired", i));
    end
    bus.zf = 1'b0;
    bus.nf = 1'b0;

    // CALL, RET, JMP
    bus.opcode = 4'd13;
    bus.reg_wr = 1'b1;
    expect_cycle("call_fetch", 3'd0, FETCH_GO);
    expect_cycle("call_dec",   3'd1, CALL_DEC);
    bus.opcode = 4'd14;
    expect_cycle("ret_fetch",  3'd0, FETCH_GO);
    expect_cycle("ret_dec",    3'd1, RET_DEC);
    bus.opcode = 4'd12;
    bus.reg_wr = 1'b0;
    expect_cycle("jmp_fetch",  3'd0, FETCH_GO);
    expect_cycle("jmp_dec",    3'd1, JMP_DEC);
    exp_ret = exp_ret + 16'd3;
    check_retired("jump_retired");

    // Counter wrap: load 0xFFFF into the count, then retire one more JMP
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFF;
    expect_cycle("wrap_fetch", 3'd0, FETCH_GO);
    expect_cycle("wrap_dec",   3'd1, JMP_DEC);
    exp_ret = exp_ret + 16'd1;
    check_retired("wrap_retired");
    expect_cycle("end_fetch",  3'd0, FETCH_GO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_sequencer.md
# multi_cycle_sequencer

Multi-cycle state sequencer for the 16-bit RISC core. It steps each instruction through Fetch, Decode, Execute, Memory and Write-back, and produces the per-cycle write and read strobes. The level-type decode outputs of the main control unit (register write, memory read, memory write) are gated through this block. It also resolves branch outcomes from ALU flags, stalls on memory ready, and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  instruction opcode from the IR; sampled in DECODE and used through EX/MEM/WB.
- reg_wr  in  1  main control register-write level.
- mem_rd  in  1  main control data-memory-read level.
- mem_wr  in  1  main control data-memory-write level.
- zf  in  1  ALU zero flag for (A − B), valid in EX.
- nf  in  1  ALU negative flag for (A − B), valid in EX.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- inst_rd  out  1  instruction memory read strobe.
- ir_wr  out  1  instruction register load.
- pc_wr  out  1  PC load.
- pc_src  out  2  PC source: 0=PC+1, 1=jump target, 2=branch target, 3=return address.
- reg_wr_en  out  1  gated register-file write.
- dmem_rd_en  out  1  gated data memory read.
- dmem_wr_en  out  1  gated data memory write.
- retired  out  16  retired-instruction count; wraps.

## Operation
- Opcode classes:
  - ALU: 0000–0100.
  - LOAD: 0101, 0110.
  - STORE: 0111, 1111.
  - BRANCH: 1000 BGT, 1001 BLT, 1010 BEQ, 1011 BNE.
  - JMP: 1100.
  - CALL: 1101.
  - RET: 1110.
- The opcode is latched into an internal register on the DECODE cycle. EX, MEM and WB use the latched copy. All 16 opcodes are defined, so there is no illegal state path.
- State paths:
  - ALU: FETCH→DECODE→EXEC→WB→FETCH.
  - LOAD: FETCH→DECODE→EXEC→MEM→WB→FETCH.
  - STORE: FETCH→DECODE→EXEC→MEM→FETCH.
  - BRANCH: FETCH→DECODE→EXEC→FETCH.
  - JMP, CALL, RET: FETCH→DECODE→FETCH.
- FETCH:
  - inst_rd=1 throughout.
  - While imem_ready=0, stay in FETCH with ir_wr=pc_wr=0.
  - On imem_ready=1: ir_wr=1, pc_wr=1, pc_src=0, next state DECODE.
- DECODE:
  - JMP: pc_wr=1, pc_src=1.
  - CALL: pc_wr=1, pc_src=1, reg_wr_en=reg_wr (writes the return address, i.e. the already-incremented PC).
  - RET: pc_wr=1, pc_src=3.
  - All other classes: no strobes.
- EXEC:
  - For BRANCH, the taken condition is:
    - BGT: !zf && !nf
    - BLT: nf
    - BEQ: zf
    - BNE: !zf
  - If taken: pc_wr=1, pc_src=2. Otherwise no PC write.
- MEM:
  - dmem_rd_en=mem_rd and dmem_wr_en=mem_wr, held every cycle until dmem_ready=1.
  - On dmem_ready=1: LOAD goes to WB; STORE goes to FETCH.
- WB: reg_wr_en=reg_wr for one cycle, then FETCH.
- Retirement: retired increments by 1 on the final cycle of each instruction.
  - The final cycle is the cycle whose next state is FETCH.
  - Counter wraps 0xFFFF→0x0000.
- Default: any strobe not listed for a state is 0. pc_src=0 whenever pc_wr=0.

## Timing
- Reset: while rst=1 at a rising edge, the following load next cycle: state=FETCH, latched opcode=0, retired=0.
- Strobe outputs are combinational from the registered state, latched opcode and inputs.
- While rst=1 all strobes (inst_rd, ir_wr, pc_wr, reg_wr_en, dmem_rd_en, dmem_wr_en) are forced 0 and pc_src=0.
- Reset mid-instruction, including MEM with an access in flight: the state is abandoned, strobes drop in the same cycle, and the instruction is not counted.
- Minimum latencies with zero wait states:
  - JMP/CALL/RET: 2 cycles.
  - BRANCH: 3 cycles.
  - ALU and STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each cycle of imem_ready=0 in FETCH or dmem_ready=0 in MEM adds exactly one cycle.
- A ready that is high on the first cycle of FETCH or MEM completes in that cycle.
- Flags zf/nf are sampled only in EXEC. They are ignored in all other states.

## Test plan
- Reset, then ADD (opcode 0000, reg_wr=1) with both readies tied 1:
  - states 0,1,2,4,0.
  - ir_wr and pc_wr in cycle 0 only; reg_wr_en in cycle 3 only.
  - retired=1 afterwards.
- LW (0101) with dmem_ready low for 2 MEM cycles:
  - dmem_rd_en high for 3 cycles, then WB with reg_wr_en=1.
  - Total 7 cycles.
- BEQ (1010) with zf=1 → EXEC pc_wr=1, pc_src=2. BNE (1011) with zf=1 → no pc_wr in EXEC. Each returns to FETCH after 3 cycles.
- CALL (1101) then RET (1110):
  - CALL: DECODE asserts pc_wr, pc_src=1, reg_wr_en=1.
  - RET: DECODE asserts pc_wr, pc_src=3.
  - Each takes 2 cycles.
- SW (0111) with rst asserted during MEM while dmem_ready=0:
  - dmem_wr_en drops in the rst cycle.
  - state=0 next cycle and retired unchanged.
- Preload retired to 0xFFFF via 65535 JMPs, then one more JMP → retired=0x0000.
